alu_instr_encoder: RTL and testbench
====================================

// Module: alu_instr_encoder
// PURPOSE
//  Reverse of the ALU control decode: turns a 4-bit ALU opcode plus register/immediate
//  fields into a legal RV32I OP (R-type) or OP-IMM (I-type) instruction word. Ops enter on a
//  valid/ready port, are encoded, buffered in a DEPTH-entry FIFO and leave on a second
//  valid/ready port. Feeds instruction-memory loaders and self-check program generators.
// PARAMETERS
//  DEPTH  4   output FIFO entries; power of 2, >= 2
//  CNT_W  16  width of instr_cnt_o and err_cnt_o
// PORTS
//  clk_i         in   1   clock, all state on rising edge
//  rst_ni        in   1   asynchronous, active-low reset
//  flush_i       in   1   synchronous FIFO clear
//  op_valid_i    in   1   encode request valid
//  op_ready_o    out  1   request accepted when valid & ready
//  alu_op_i      in   4   0 add,1 sub,2 sll,3 slt,4 sltu,5 xor,6 sra,7 srl,8 or,9 and
//  imm_sel_i     in   1   0: R-type (rs2_i), 1: I-type (imm_i)
//  rd_i          in   5   destination register
//  rs1_i         in   5   source register 1
//  rs2_i         in   5   source register 2 (R-type only)
//  imm_i         in   12  immediate; shifts use imm_i[4:0] as shamt
//  instr_valid_o out  1   FIFO head valid
//  instr_ready_i in   1   consumer takes head when valid & ready
//  instr_o       out  32  encoded instruction at FIFO head
//  err_o         out  1   1-cycle pulse: illegal request dropped
//  instr_cnt_o   out  CNT_W instructions delivered (output handshakes)
//  err_cnt_o     out  CNT_W illegal requests dropped
// BEHAVIOUR
//  - Reset (async, rst_ni=0): FIFO empty, instr_valid_o=0, instr_o=0, err_o=0, counters=0;
//    op_ready_o=1 once empty. Reset mid-transfer discards all buffered entries.
//  - op_ready_o = ~full & ~flush_i. No pass-through: full FIFO blocks input even if popping.
//  - Encoding: func3 add/sub 000, sll 001, slt 010, sltu 011, xor 100, sra/srl 101, or 110,
//    and 111; func7 0100000 for sub/sra, else 0000000.
//    R: {func7,rs2,rs1,func3,rd,7'b0110011}. I: {imm_i,rs1,func3,rd,7'b0010011}, except
//    shifts: {func7,imm_i[4:0],rs1,func3,rd,7'b0010011} (imm_i[11:5] ignored).
//  - Illegal: alu_op_i>=10 (any type), or sub with imm_sel_i=1. Request still handshakes
//    (op_ready_o rules unchanged), is NOT written; err_o=1 next cycle, err_cnt_o+1.
//  - Latency: accepted legal op visible on instr_o/instr_valid_o the next cycle if FIFO was
//    empty; otherwise in order behind older entries. instr_o is the registered head entry,
//    holds stable while instr_valid_o & ~instr_ready_i; instr_o=0 when empty.
//  - Push and pop same cycle (not full, not empty): occupancy unchanged, both complete.
//  - Pointers log2(DEPTH)+1 bits, wrap naturally; full/empty from MSB compare.
//  - flush_i: next cycle FIFO empty; a pop in the flush cycle still counts; push blocked.
//  - Counters wrap at 2^CNT_W-1 -> 0, no saturation.
// TESTING
//  1. ADD R: op=0,rd=3,rs1=1,rs2=2 -> instr_o=0x002081B3 next cycle, instr_cnt_o=1 after pop.
//  2. SUB R: op=1,rd=5,rs1=6,rs2=7 -> 0x407302B3; SRAI: op=6,imm_sel=1,rd=1,rs1=2,imm=0xFE3
//     -> 0x40315093; ADDI x1,x0,-1 -> 0xFFF00093.
//  3. Illegal op=12, and SUB with imm_sel=1 -> nothing enqueued, err_o pulses, err_cnt_o=2.
//  4. Hold instr_ready_i=0, push 5 ops with DEPTH=4 -> op_ready_o=0 after 4th, 5th waits;
//     release -> all 5 emerge in order, stable while stalled.
//  5. Simultaneous push/pop at occupancy 2 for 10 cycles -> occupancy stays 2, order kept.
//  6. Fill 3 entries, assert rst_ni=0 async mid-cycle -> instr_valid_o=0, counters 0
//     immediately; same with flush_i -> empty next cycle, counters retained.

Source files
------------

// File: rtl/alu_instr_encoder_if.sv
// alu_instr_encoder_if: request/response bundle for the ALU instruction encoder
//  master: drives flush, op request fields and instr_ready_i; sees the encoded stream
//  slave : the encoder side of the same signals
interface alu_instr_encoder_if #(
  parameter int CNT_W = 16
);
  logic             flush_i;
  logic             op_valid_i;
  logic             op_ready_o;
  logic [3:0]       alu_op_i;
  logic             imm_sel_i;
  logic [4:0]       rd_i;
  logic [4:0]       rs1_i;
  logic [4:0]       rs2_i;
  logic [11:0]      imm_i;
  logic             instr_valid_o;
  logic             instr_ready_i;
  logic [31:0]      instr_o;
  logic             err_o;
  logic [CNT_W-1:0] instr_cnt_o;
  logic [CNT_W-1:0] err_cnt_o;
  modport master (
    output flush_i, op_valid_i, alu_op_i, imm_sel_i, rd_i, rs1_i, rs2_i, imm_i, instr_ready_i,
    input  op_ready_o, instr_valid_o, instr_o, err_o, instr_cnt_o, err_cnt_o
  );
  modport slave (
    input  flush_i, op_valid_i, alu_op_i, imm_sel_i, rd_i, rs1_i, rs2_i, imm_i, instr_ready_i,
    output op_ready_o, instr_valid_o, instr_o, err_o, instr_cnt_o, err_cnt_o
  );
endinterface

// File: rtl/alu_instr_encoder.sv
// alu_instr_encoder: encodes ALU ops into RV32I OP/OP-IMM words through an output FIFO
//  clk_i  : clock, rising edge
//  rst_ni : asynchronous active-low reset
//  bus    : slave side of alu_instr_encoder_if (op request in, instruction stream out,
//           error pulse and delivered/dropped counters)
module alu_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic                clk_i,
  input logic                rst_ni,
  alu_instr_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]      mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             full, empty, acc, push, pop, illegal, alt, shift;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [11:0]      upper;
  logic [31:0]      enc;
  logic             err_q;
  logic [CNT_W-1:0] instr_cnt, err_cnt;
  always_comb begin
    f3 = 3'b000;
    case (bus.alu_op_i)
      4'd2:       f3 = 3'b001;
      4'd3:       f3 = 3'b010;
      4'd4:       f3 = 3'b011;
      4'd5:       f3 = 3'b100;
      4'd6, 4'd7: f3 = 3'b101;
      4'd8:       f3 = 3'b110;
      4'd9:       f3 = 3'b111;
      default:    f3 = 3'b000;
    endcase
  end
  assign alt     = bus.alu_op_i == 4'd1 || bus.alu_op_i == 4'd6;
  assign shift   = bus.alu_op_i == 4'd2 || bus.alu_op_i == 4'd6 || bus.alu_op_i == 4'd7;
  assign f7      = alt ? 7'b0100000 : 7'b0000000;
  // the top 12 bits carry rs2, the immediate, or func7 plus shamt for immediate shifts
  assign upper   = bus.imm_sel_i ? (shift ? {f7, bus.imm_i[4:0]} : bus.imm_i) : {f7, bus.rs2_i};
  assign enc     = {upper, bus.rs1_i, f3, bus.rd_i, bus.imm_sel_i ? 7'b0010011 : 7'b0110011};
  assign illegal = bus.alu_op_i > 4'd9 || (bus.alu_op_i == 4'd1 && bus.imm_sel_i);
  assign empty   = wptr == rptr;
  assign full    = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
  assign acc     = bus.op_valid_i && bus.op_ready_o;
  assign push    = acc && !illegal;
  assign pop     = bus.instr_valid_o && bus.instr_ready_i;
  assign bus.op_ready_o    = !full && !bus.flush_i;
  assign bus.instr_valid_o = !empty;
  assign bus.instr_o       = empty ? 32'h0 : mem[rptr[AW-1:0]];
  assign bus.err_o         = err_q;
  assign bus.instr_cnt_o   = instr_cnt;
  assign bus.err_cnt_o     = err_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr      <= '0;
      rptr      <= '0;
      err_q     <= 1'b0;
      instr_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (bus.flush_i) rptr <= wptr;
      else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
      end
      err_q     <= acc && illegal;
      err_cnt   <= err_cnt + CNT_W'(acc && illegal);
      instr_cnt <= instr_cnt + CNT_W'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr[AW-1:0]] <= enc;
  end
endmodule

// File: tb/tb_alu_instr_encoder.sv
// tb_alu_instr_encoder: directed and randomized checks of alu_instr_encoder against a queue model
module tb_alu_instr_encoder;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;
  alu_instr_encoder_if #(.CNT_W(CNT_W)) bus ();
  alu_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [CNT_W-1:0] icnt = '0;
  logic [CNT_W-1:0] ecnt = '0;
  logic err_exp = 1'b0;
  bit [2:0] f3tab [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};

  function automatic bit legal(int op, bit isel);
    return op < 10 && !(op == 1 && isel);
  endfunction

  function automatic logic [31:0] model_enc(int op, bit isel, int rd, int rs1, int rs2, int imm);
    int f7, hi, opc;
    f7  = (op == 1 || op == 6) ? 32 : 0;
    opc = isel ? 'h13 : 'h33;
    if (!isel) hi = f7 * 32 + rs2;
    else if (op == 2 || op == 6 || op == 7) hi = f7 * 32 + (imm % 32);
    else hi = imm;
    return 32'(hi * (1 << 20) + rs1 * (1 << 15) + int'(f3tab[op]) * (1 << 12) + rd * (1 << 7) + opc);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s", tag);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".valid"}, 32'(bus.instr_valid_o), 32'(q.size() != 0));
    chk({tag, ".instr"}, bus.instr_o, q.size() != 0 ? q[0] : 32'h0);
    chk({tag, ".ready"}, 32'(bus.op_ready_o), 32'(q.size() < DEPTH && !bus.flush_i));
    chk({tag, ".err"}, 32'(bus.err_o), 32'(err_exp));
    chk({tag, ".icnt"}, 32'(bus.instr_cnt_o), 32'(icnt));
    chk({tag, ".ecnt"}, 32'(bus.err_cnt_o), 32'(ecnt));
  endtask

  task automatic model_update();
    bit acc, pop, ok;
    acc = bus.op_valid_i && q.size() < DEPTH && !bus.flush_i;
    pop = q.size() != 0 && bus.instr_ready_i;
    ok  = legal(int'(bus.alu_op_i), bus.imm_sel_i);
    if (pop) begin
      void'(q.pop_front());
      icnt++;
    end
    if (bus.flush_i) q.delete();
    else if (acc && ok)
      q.push_back(model_enc(int'(bus.alu_op_i), bus.imm_sel_i, int'(bus.rd_i), int'(bus.rs1_i),
                            int'(bus.rs2_i), int'(bus.imm_i)));
    err_exp = acc && !ok;
    if (acc && !ok) ecnt++;
  endtask

  task automatic step(string tag);
    #1;
    check_all(tag);
    model_update();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive(int op, bit isel, int rd, int rs1, int rs2, int imm);
    bus.op_valid_i = 1'b1;
    bus.alu_op_i   = 4'(op);
    bus.imm_sel_i  = isel;
    bus.rd_i       = 5'(rd);
    bus.rs1_i      = 5'(rs1);
    bus.rs2_i      = 5'(rs2);
    bus.imm_i      = 12'(imm);
  endtask

  task automatic drive_rand_legal();
    int op;
    bit isel;
    op   = $urandom_range(0, 9);
    isel = 1'($urandom);
    if (op == 1) isel = 1'b0;
    drive(op, isel, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 4095));
  endtask

  initial begin
    bus.flush_i = 1'b0;
    bus.instr_ready_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    bus.op_valid_i = 1'b0;
    #3;
    chk("rst.valid", 32'(bus.instr_valid_o), 32'd0);
    chk("rst.instr", bus.instr_o, 32'h0);
    chk("rst.err", 32'(bus.err_o), 32'd0);
    chk("rst.cnts", {bus.instr_cnt_o, bus.err_cnt_o}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("idle");
    // ADD R-type, then pop
    drive(0, 0, 3, 1, 2, 0);
    step("add_push");
    bus.op_valid_i = 1'b0;
    chk("add_word", bus.instr_o, 32'h002081B3);
    bus.instr_ready_i = 1'b1;
    step("add_pop");
    chk("add_cnt", 32'(bus.instr_cnt_o), 32'd1);
    bus.instr_ready_i = 1'b0;
    drive(1, 0, 5, 6, 7, 0);
    step("sub_push");
    bus.op_valid_i = 1'b0;
    chk("sub_word", bus.instr_o, 32'h407302B3);
    bus.instr_ready_i = 1'b1;
    step("sub_pop");
    bus.instr_ready_i = 1'b0;
    drive(6, 1, 1, 2, 0, 'hFE3);
    step("srai_push");
    bus.op_valid_i = 1'b0;
    chk("srai_word", bus.instr_o, 32'h40315093);
    bus.instr_ready_i = 1'b1;
    step("srai_pop");
    bus.instr_ready_i = 1'b0;
    drive(0, 1, 1, 0, 0, 'hFFF);
    step("addi_push");
    bus.op_valid_i = 1'b0;
    chk("addi_word", bus.instr_o, 32'hFFF00093);
    bus.instr_ready_i = 1'b1;
    step("addi_pop");
    bus.instr_ready_i = 1'b0;
    // illegal requests
    drive(12, 0, 1, 1, 1, 0);
    step("ill_op");
    bus.op_valid_i = 1'b0;
    chk("ill_op_err", 32'(bus.err_o), 32'd1);
    step("ill_gap");
    drive(1, 1, 1, 1, 1, 5);
    step("ill_subi");
    bus.op_valid_i = 1'b0;
    chk("ill_subi_err", 32'(bus.err_o), 32'd1);
    chk("ill_ecnt", 32'(bus.err_cnt_o), 32'd2);
    chk("ill_empty", 32'(bus.instr_valid_o), 32'd0);
    step("ill_after");
    // fill to full with consumer stalled; fifth op waits
    for (int i = 0; i < 5; i++) begin
      drive(5, 0, i + 1, i, i + 2, 0);
      step("full_push");
    end
    chk("full_ready", 32'(bus.op_ready_o), 32'd0);
    step("full_hold");
    bus.instr_ready_i = 1'b1;
    step("full_pop");
    step("full_fifth");
    bus.op_valid_i = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) step("full_drain");
    chk("full_cnt", 32'(bus.instr_cnt_o), 32'(icnt));
    // push and pop together at occupancy 2
    bus.instr_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_rand_legal();
      step("occ_fill");
    end
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_rand_legal();
      step("occ_pp");
    end
    bus.op_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step("occ_drain");
    // async reset with three entries buffered
    bus.instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand_legal();
      step("arst_fill");
    end
    bus.op_valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("arst_instr", bus.instr_o, 32'h0);
    chk("arst_cnts", {bus.instr_cnt_o, bus.err_cnt_o}, 32'h0);
    q.delete();
    icnt = '0;
    ecnt = '0;
    err_exp = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("arst_after");
    // flush with three entries, popping in the flush cycle
    for (int i = 0; i < 3; i++) begin
      drive_rand_legal();
      step("flush_fill");
    end
    bus.flush_i = 1'b1;
    bus.instr_ready_i = 1'b1;
    drive_rand_legal();
    step("flush_cyc");
    bus.flush_i = 1'b0;
    bus.op_valid_i = 1'b0;
    bus.instr_ready_i = 1'b0;
    chk("flush_empty", 32'(bus.instr_valid_o), 32'd0);
    chk("flush_cnt", 32'(bus.instr_cnt_o), 32'd1);
    step("flush_after");
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 11), 1'($urandom), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 4095));
      bus.op_valid_i    = ($urandom % 4) != 0;
      bus.instr_ready_i = ($urandom % 3) != 0;
      bus.flush_i       = ($urandom % 32) == 0;
      step("rand");
    end
    bus.op_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) step("rand_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
